// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the two-client signed multiply sequencer.
package mult_sched_pkg;

  localparam int NUM_CLIENTS = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    CAPT  = 3'd4
  } state_t;

endpackage

// File: rtl/mult_sched_if.sv
// Client request/response and datapath strobe bundle for mult_sched.
interface mult_sched_if
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic [NUM_CLIENTS-1:0] req;
  logic [WIDTH-1:0]       op_a0;
  logic [WIDTH-1:0]       op_b0;
  logic [WIDTH-1:0]       op_a1;
  logic [WIDTH-1:0]       op_b1;
  logic [NUM_CLIENTS-1:0] gnt;
  logic [NUM_CLIENTS-1:0] done;
  logic [2*WIDTH-1:0]     result;
  logic                   busy;
  logic                   dp_load;
  logic                   dp_add;
  logic                   dp_sub;
  logic                   dp_shift;
  logic [WIDTH-1:0]       dp_mcand;
  logic [WIDTH-1:0]       dp_mplier;
  logic                   dp_m;
  logic [WIDTH-1:0]       dp_a;
  logic [WIDTH-1:0]       dp_b;

  modport slave (
    input  req, op_a0, op_b0, op_a1, op_b1, dp_m, dp_a, dp_b,
    output gnt, done, result, busy,
    output dp_load, dp_add, dp_sub, dp_shift, dp_mcand, dp_mplier
  );

  modport master (
    output req, op_a0, op_b0, op_a1, op_b1, dp_m, dp_a, dp_b,
    input  gnt, done, result, busy,
    input  dp_load, dp_add, dp_sub, dp_shift, dp_mcand, dp_mplier
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin owner select; the previous owner loses a tie.
module rr_arb2
  import mult_sched_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic                   last_owner,
  output logic [NUM_CLIENTS-1:0] grant,
  output logic                   any_req
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_owner ? 2'b01 : 2'b10;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mult_sched.sv
// Arbitrates two multiply clients and sequences the shared add-shift datapath
// through a signed multiply, returning the product with a one-cycle done pulse.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  mult_sched_if.slave bus
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t                 state_reg;
  state_t                 state_next;
  logic [CW-1:0]          cnt_reg;
  logic                   owner_reg;
  logic                   last_owner_reg;
  logic [WIDTH-1:0]       mcand_reg;
  logic [WIDTH-1:0]       mplier_reg;
  logic [2*WIDTH-1:0]     result_reg;
  logic [NUM_CLIENTS-1:0] done_reg;

  logic [NUM_CLIENTS-1:0] arb_grant;
  logic                   arb_any;
  logic                   last_bit;
  logic                   busy;
  logic                   load_next;
  logic                   add_next;
  logic                   sub_next;
  logic                   shift_next;

  rr_arb2 u_arb (
    .req        (bus.req),
    .last_owner (last_owner_reg),
    .grant      (arb_grant),
    .any_req    (arb_any)
  );

  assign last_bit = (cnt_reg == CNT_LAST);
  assign busy     = (state_reg != IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The top multiplier bit carries negative weight, so it subtracts.
  always_comb begin
    state_next = state_reg;
    load_next  = 1'b0;
    add_next   = 1'b0;
    sub_next   = 1'b0;
    shift_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (arb_any) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        load_next  = 1'b1;
        state_next = ADD;
      end
      ADD: begin
        add_next   = bus.dp_m & ~last_bit;
        sub_next   = bus.dp_m & last_bit;
        state_next = SHIFT;
      end
      SHIFT: begin
        shift_next = 1'b1;
        state_next = last_bit ? CAPT : ADD;
      end
      CAPT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_reg        <= '0;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;
      mcand_reg      <= '0;
      mplier_reg     <= '0;
      result_reg     <= '0;
      done_reg       <= '0;
    end else begin
      done_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (arb_any) begin
            owner_reg  <= arb_grant[1];
            mcand_reg  <= arb_grant[1] ? bus.op_a1 : bus.op_a0;
            mplier_reg <= arb_grant[1] ? bus.op_b1 : bus.op_b0;
            cnt_reg    <= '0;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        CAPT: begin
          result_reg          <= {bus.dp_a, bus.dp_b};
          done_reg[owner_reg] <= 1'b1;
          last_owner_reg      <= owner_reg;
        end
        default: begin
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIENTS; gi = gi + 1) begin : g_gnt
      assign bus.gnt[gi] = busy && (owner_reg == 1'(gi));
    end
  endgenerate

  assign bus.done      = done_reg;
  assign bus.result    = result_reg;
  assign bus.busy      = busy;
  assign bus.dp_load   = load_next;
  assign bus.dp_add    = add_next;
  assign bus.dp_sub    = sub_next;
  assign bus.dp_shift  = shift_next;
  assign bus.dp_mcand  = mcand_reg;
  assign bus.dp_mplier = mplier_reg;

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched with a behavioural add-shift datapath attached.
module tb_mult_sched;

  localparam int W = 8;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  mult_sched_if #(.WIDTH(W)) bus ();

  mult_sched #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Shared datapath: X:A:B shift register with a W+1 bit adder/subtractor.
  logic [W-1:0] a_q, b_q;
  logic         x_q;
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_q <= '0; b_q <= '0; x_q <= 1'b0;
    end else if (bus.dp_load) begin
      a_q <= '0; b_q <= bus.dp_mplier; x_q <= 1'b0;
    end else if (bus.dp_add) begin
      {x_q, a_q} <= {x_q, a_q} + {bus.dp_mcand[W-1], bus.dp_mcand};
    end else if (bus.dp_sub) begin
      {x_q, a_q} <= {x_q, a_q} - {bus.dp_mcand[W-1], bus.dp_mcand};
    end else if (bus.dp_shift) begin
      a_q <= {x_q, a_q[W-1:1]};
      b_q <= {a_q[0], b_q[W-1:1]};
    end
  end
  assign bus.dp_a = a_q;
  assign bus.dp_b = b_q;
  assign bus.dp_m = b_q[0];

  typedef struct {
    logic [1:0]  owner;
    logic [15:0] res;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_add    = 0;
  int   n_sub    = 0;
  int   n_shift  = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic push_exp(input logic [1:0] o, input logic [15:0] r, input int c);
    exp_t e;
    e.owner = o; e.res = r; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Strobe tally per operation, restarted by each load.
  always @(negedge Clk) begin
    if (bus.dp_load) begin
      n_add = 0; n_sub = 0; n_shift = 0;
    end else begin
      n_add   += int'(bus.dp_add);
      n_sub   += int'(bus.dp_sub);
      n_shift += int'(bus.dp_shift);
    end
  end

  // Monitor: grant ownership and every done pulse against the scoreboard head.
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      chk("strobe_onehot", 32'($countones({bus.dp_load, bus.dp_add, bus.dp_sub, bus.dp_shift}) <= 1), 32'd1);
      chk("done_not_both", 32'(bus.done != 2'b11), 32'd1);
      if (bus.busy) begin
        if (exp_q.size() == 0) chk("busy_unexpected", 32'(bus.busy), 32'd0);
        else                   chk("gnt_owner", 32'(bus.gnt), 32'(exp_q[0].owner));
      end else begin
        chk("gnt_idle", 32'(bus.gnt), 32'd0);
      end
      if (bus.done != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 32'(bus.done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_owner", 32'(bus.done), 32'(e.owner));
          chk("result", 32'(bus.result), 32'(e.res));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("busy_at_done", 32'(bus.busy), 32'd0);
        end
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (bus.done == 2'b00 && n < 40);
    chk("done_seen", 32'(bus.done != 2'b00), 32'd1);
  endtask

  task automatic run_single(input bit client, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] r);
    @(negedge Clk);
    if (client) begin
      bus.op_a1 = a; bus.op_b1 = b; bus.req = 2'b10;
    end else begin
      bus.op_a0 = a; bus.op_b0 = b; bus.req = 2'b01;
    end
    push_exp(client ? 2'b10 : 2'b01, r, cyc + 19);
    @(negedge Clk);
    bus.req = 2'b00;
    wait_done();
    $display("op client%0d a=%02h b=%02h -> result=%04h done=%b", client, a, b, bus.result, bus.done);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 2'b00;
    bus.op_a0 = '0; bus.op_b0 = '0; bus.op_a1 = '0; bus.op_b1 = '0;
    repeat (2) @(negedge Clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_strobes", 32'({bus.dp_load, bus.dp_add, bus.dp_sub, bus.dp_shift}), 32'd0);
    chk("rst_operands", 32'({bus.dp_mcand, bus.dp_mplier}), 32'd0);
    Reset = 1'b0;

    // 7 * -3
    run_single(1'b0, 8'd7, 8'hFD, 16'hFFEB);
    chk("adds_7xfd", 32'(n_add), 32'd6);
    chk("subs_7xfd", 32'(n_sub), 32'd1);
    chk("shifts_7xfd", 32'(n_shift), 32'd8);

    // Contention from reset: client 0 first, then client 1
    do_reset();
    @(negedge Clk);
    bus.op_a0 = 8'h80; bus.op_b0 = 8'h80; bus.op_a1 = 8'd5; bus.op_b1 = 8'd6;
    bus.req = 2'b11;
    push_exp(2'b01, 16'h4000, cyc + 19);
    push_exp(2'b10, 16'h001E, cyc + 38);
    wait_done();
    $display("contend first: result=%04h done=%b", bus.result, bus.done);
    repeat (2) @(negedge Clk);
    bus.req = 2'b00;
    wait_done();
    $display("contend second: result=%04h done=%b", bus.result, bus.done);

    // Both held for four operations: 0,1,0,1
    @(negedge Clk);
    bus.op_a0 = 8'd3; bus.op_b0 = 8'd4; bus.op_a1 = 8'hFE; bus.op_b1 = 8'd9;
    bus.req = 2'b11;
    push_exp(2'b01, 16'h000C, cyc + 19);
    push_exp(2'b10, 16'hFFEE, cyc + 38);
    push_exp(2'b01, 16'h000C, cyc + 57);
    push_exp(2'b10, 16'hFFEE, cyc + 76);
    for (int i = 0; i < 3; i++) begin
      wait_done();
      $display("rr op %0d: result=%04h done=%b", i, bus.result, bus.done);
    end
    repeat (2) @(negedge Clk);
    bus.req = 2'b00;
    wait_done();
    $display("rr op 3: result=%04h done=%b", bus.result, bus.done);

    // Operands change and req drops mid-operation
    @(negedge Clk);
    bus.op_a0 = 8'd3; bus.op_b0 = 8'd5; bus.req = 2'b01;
    push_exp(2'b01, 16'h000F, cyc + 19);
    repeat (5) @(negedge Clk);
    bus.op_a0 = 8'h80; bus.op_b0 = 8'h7F; bus.req = 2'b00;
    wait_done();
    $display("latched operands: result=%04h done=%b", bus.result, bus.done);

    // Asynchronous reset in cycle 10 of an operation
    @(negedge Clk);
    bus.op_a0 = 8'h11; bus.op_b0 = 8'h22; bus.req = 2'b01;
    push_exp(2'b01, 16'h0242, cyc + 19);
    @(negedge Clk);
    bus.req = 2'b00;
    repeat (9) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("arst_gnt", 32'(bus.gnt), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_result", 32'(bus.result), 32'd0);
    chk("arst_strobes", 32'({bus.dp_load, bus.dp_add, bus.dp_sub, bus.dp_shift}), 32'd0);
    $display("async reset mid-op: gnt=%b busy=%b result=%04h", bus.gnt, bus.busy, bus.result);
    exp_q.delete();
    @(negedge Clk);
    bus.op_a0 = 8'hFF; bus.op_b0 = 8'hFF; bus.op_a1 = 8'h7F; bus.op_b1 = 8'h80;
    bus.req = 2'b11;
    Reset = 1'b0;
    push_exp(2'b01, 16'h0001, cyc + 19);
    push_exp(2'b10, 16'hC080, cyc + 38);
    wait_done();
    $display("post-reset first: result=%04h done=%b", bus.result, bus.done);
    repeat (2) @(negedge Clk);
    bus.req = 2'b00;
    wait_done();
    $display("post-reset second: result=%04h done=%b", bus.result, bus.done);

    // Multiplier edge cases
    run_single(1'b0, 8'd1, 8'h00, 16'h0000);
    chk("adds_b0", 32'(n_add), 32'd0);
    chk("subs_b0", 32'(n_sub), 32'd0);
    run_single(1'b0, 8'd1, 8'h80, 16'hFF80);
    chk("adds_b80", 32'(n_add), 32'd0);
    chk("subs_b80", 32'(n_sub), 32'd1);

    repeat (25) @(negedge Clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_sched.md
Name: mult_sched

Overview:
- Sequencer and two-port arbiter for the shared signed add-shift multiplier datapath (A/B shift registers, X sign bit, WIDTH-bit adder/subtractor).
- Accepts multiply requests from two clients and grants one at a time, round-robin.
- Drives the datapath's load/add/sub/shift strobes for the full signed multiply, captures the 2*WIDTH product and returns it to the owner with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand width; product is 2*WIDTH bits; compute phase is 2*WIDTH cycles.

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high; clears all state
req  in  2  per-client request level; held until that client's done
op_a0, op_b0  in  WIDTH each  client 0 multiplicand / multiplier (signed)
op_a1, op_b1  in  WIDTH each  client 1 multiplicand / multiplier (signed)
gnt  out  2  one-hot owner indication, LOAD through CAPT
done  out  2  one-cycle pulse to owner, result valid that cycle
result  out  2*WIDTH  registered signed product, holds until next capture
busy  out  1  high whenever state != IDLE
dp_load  out  1  datapath: load B with multiplier, clear A and X
dp_add  out  1  datapath: A,X <= A + multiplicand (sign-extended)
dp_sub  out  1  datapath: A,X <= A - multiplicand
dp_shift  out  1  datapath: arithmetic right shift of X:A:B
dp_mcand  out  WIDTH  multiplicand to adder, from latched operand register
dp_mplier  out  WIDTH  multiplier to B load, from latched operand register
dp_m  in  1  datapath B[0]
dp_a, dp_b  in  WIDTH each  datapath A and B registers

Behaviour:
- Reset (async): state=IDLE; gnt=0; done=0; result=0; cnt=0; last_owner=1, so client 0 wins first contention. All dp_* strobes are 0. Latched operands are 0.
- Reset mid-operation aborts immediately. No done pulse is produced and result keeps 0.
- States: IDLE, LOAD, ADD, SHIFT, CAPT.
- IDLE, any req set: pick owner, latch op_a/op_b of the owner into mcand_q/mplier_q on the same edge, go to LOAD.
  - Both req set: owner = ~last_owner.
  - Otherwise: owner = the requester that is set.
- LOAD (1 cycle): dp_load=1. -> ADD with cnt=0.
- ADD: dp_add = dp_m & (cnt != WIDTH-1); dp_sub = dp_m & (cnt == WIDTH-1). -> SHIFT.
- SHIFT: dp_shift=1.
  - cnt == WIDTH-1: go to CAPT.
  - Otherwise: cnt++ and go to ADD.
- CAPT: result <= {dp_a, dp_b}; done[owner] <= 1 (registered, high the next cycle); last_owner <= owner. -> IDLE.
- Exactly one dp_* strobe is high per cycle, or none.
- gnt[owner] is high in LOAD, ADD, SHIFT and CAPT; otherwise 0.
- Latency, WIDTH=8: req sampled at edge 0 -> LOAD cycle 1, ADD/SHIFT cycles 2..17, CAPT cycle 18, done and new result in cycle 19.
  - Back-to-back: a req still high in that IDLE cycle is sampled, so throughput is one product per 19 cycles.
- req and op_* of both clients are ignored outside IDLE. Dropping req mid-op does not abort; done is still pulsed.
- A non-owner request stays pending and wins at the next IDLE.
- done is never asserted to a non-owner; at most one done bit is high.
- Arithmetic: two's complement throughout, with subtract on the final bit. The product of any two signed WIDTH-bit operands is exact in 2*WIDTH bits, including -2^(W-1) * -2^(W-1).
- cnt is a $clog2(WIDTH)-bit counter, reset to 0 on entry to LOAD. It never wraps within an operation.

Decomposition:
- Package mult_sched_pkg:
  - state enum (logic [2:0]): IDLE, LOAD, ADD, SHIFT, CAPT.
  - NUM_CLIENTS=2 constant.
- Sub-module rr_arb2: combinational owner select from req and last_owner, giving a one-hot grant. The last_owner register stays in mult_sched.

Test Plan:
- Reset then req=01, a0=7, b0=-3 (8'hFD) -> LOAD at cycle 1, 16 alternating ADD/SHIFT cycles, done=01 at cycle 19, result=16'hFFEB; gnt=01 in cycles 1-18.
- req=11 from reset, a0=-128, b0=-128, a1=5, b1=6 -> client 0 first: result 16'h4000 with done=01. Client 1 next: result 16'h001E with done=10, 19 cycles later.
- Both clients hold req for 4 operations -> grant order 0,1,0,1; done never 11; busy drops for exactly one cycle between operations.
- Client 0 changes op_a0/op_b0 and drops req at cycle 5 of an operation -> result still uses operands latched at edge 0; done=01 at cycle 19.
- Reset asserted asynchronously in cycle 10 of an operation -> all outputs 0 immediately; no done pulse; next req restarts from LOAD with client 0 priority.
- b=0 and b=8'h80 with a=1 -> no dp_add/dp_sub pulses for b=0 (result 0). Only dp_sub in bit 7 for b=8'h80 (result 16'hFF80).
